sp_packet_decoder: RTL and testbench

Service-protocol receive decoder between the SPI word receiver and the MIL transmit ring buffer.
- Consumes the raw 16-bit word stream pushed by the SPI slave and checks the packet address.
- Strips escapes, tags data and service words, and checks the 16-bit sum.
- Emits a token stream (start / data / serv / end+status) through a small output FIFO, so the downstream ring writer can commit or roll back the packet.

---
 rtl/sp_packet_decoder_if.sv | 20 ++
 rtl/sp_packet_decoder.sv | 198 +++++++++++++++++++
 tb/tb_sp_packet_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_packet_decoder_if.sv
// rtl/sp_packet_decoder_if.sv - word-in / token-out stream bundle for sp_packet_decoder
interface sp_packet_decoder_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        frame_abort;
    logic [15:0] out_data;
    logic [1:0]  out_type;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_data, in_valid, frame_abort, out_ready,
        input  out_data, out_type, out_valid
    );

    modport slave (
        input  in_data, in_valid, frame_abort, out_ready,
        output out_data, out_type, out_valid
    );
endinterface

// File: rtl/sp_packet_decoder.sv
// rtl/sp_packet_decoder.sv - service-protocol word stream to token stream decoder
// Optional packet statistics counters are built when SP_DECODER_STAT_EN is defined.
module sp_packet_decoder #(
    parameter logic [7:0]  BLOCK_ADDR = 8'hAB,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] ESC_SERV   = 16'hFFA1,
    parameter logic [15:0] ESC_DATA   = 16'hFFA3
) (
    input  logic               clk,
    input  logic               rst,
    sp_packet_decoder_if.slave bus,
`ifdef SP_DECODER_STAT_EN
    output logic [7:0]         pkt_ok_cnt,
    output logic [7:0]         pkt_err_cnt,
`endif
    output logic               busy
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] L_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] L_ROOM2 = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [1:0]  T_DATA  = 2'd0;
    localparam logic [1:0]  T_SERV  = 2'd1;
    localparam logic [1:0]  T_START = 2'd2;
    localparam logic [1:0]  T_END   = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_SIZE, S_BODY, S_ESCS, S_ESCD, S_CSUM, S_TRAIL} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_sum, w_sum_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_match, w_match_nxt;
    logic        r_started, w_started_nxt;
    logic        r_err_sum, w_err_sum_nxt;
    logic        r_err_esc, w_err_esc_nxt;
    logic        r_err_ovf, w_err_ovf_nxt;

    logic [15:0] r_mem_data [FIFO_DEPTH];
    logic [1:0]  r_mem_type [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;

    logic        w_pop, w_room2, w_wr, w_is_esc;
    logic        w_tok_req, w_end_req, w_end_abort;
    logic [1:0]  w_tok_type, w_wr_type;
    logic [15:0] w_tok_data, w_end_data, w_wr_data, w_sum_add;
    logic [7:0]  w_cnt_dec;

    assign w_pop     = (r_count != '0) && bus.out_ready;
    assign w_room2   = (r_count <= L_ROOM2);
    assign w_sum_add = r_sum + bus.in_data;
    assign w_cnt_dec = r_cnt - 8'd1;
    assign w_is_esc  = (bus.in_data == ESC_SERV) || (bus.in_data == ESC_DATA);

    always_comb begin
        w_state_nxt   = r_state;
        w_sum_nxt     = r_sum;
        w_cnt_nxt     = r_cnt;
        w_match_nxt   = r_match;
        w_started_nxt = r_started;
        w_err_sum_nxt = r_err_sum;
        w_err_esc_nxt = r_err_esc;
        w_err_ovf_nxt = r_err_ovf;
        w_tok_req     = 1'b0;
        w_tok_type    = T_DATA;
        w_tok_data    = bus.in_data;
        w_end_req     = 1'b0;
        w_end_abort   = 1'b0;
        if (bus.frame_abort) begin
            if ((r_state != S_IDLE) && r_started) begin
                w_end_req   = 1'b1;
                w_end_abort = 1'b1;
            end
            w_state_nxt   = S_IDLE;
            w_started_nxt = 1'b0;
            w_err_sum_nxt = 1'b0;
            w_err_esc_nxt = 1'b0;
            w_err_ovf_nxt = 1'b0;
        end else if (bus.in_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    w_sum_nxt     = bus.in_data;
                    w_match_nxt   = (bus.in_data[15:8] == BLOCK_ADDR);
                    w_started_nxt = 1'b0;
                    w_err_sum_nxt = 1'b0;
                    w_err_esc_nxt = 1'b0;
                    w_err_ovf_nxt = 1'b0;
                    w_state_nxt   = S_SIZE;
                end
                S_SIZE: begin
                    w_cnt_nxt     = bus.in_data[15:8];
                    w_sum_nxt     = w_sum_add;
                    w_tok_req     = r_match;
                    w_tok_type    = T_START;
                    w_started_nxt = r_match && w_room2;
                    w_state_nxt   = (bus.in_data[15:8] == 8'd0) ? S_CSUM : S_BODY;
                end
                S_BODY: begin
                    w_cnt_nxt = w_cnt_dec;
                    w_sum_nxt = w_sum_add;
                    if (bus.in_data == ESC_SERV) begin
                        w_state_nxt = S_ESCS;
                    end else if (bus.in_data == ESC_DATA) begin
                        w_state_nxt = S_ESCD;
                    end else begin
                        w_tok_req = r_match;
                    end
                    // Body length is counted in raw words, so an escape can be the last one.
                    if (w_cnt_dec == 8'd0) begin
                        w_state_nxt = S_CSUM;
                        if (w_is_esc) w_err_esc_nxt = 1'b1;
                    end
                end
                S_ESCS, S_ESCD: begin
                    w_cnt_nxt   = w_cnt_dec;
                    w_sum_nxt   = w_sum_add;
                    w_tok_req   = r_match;
                    w_tok_type  = (r_state == S_ESCS) ? T_SERV : T_DATA;
                    w_state_nxt = (w_cnt_dec == 8'd0) ? S_CSUM : S_BODY;
                end
                S_CSUM: begin
                    if (bus.in_data != r_sum) w_err_sum_nxt = 1'b1;
                    w_state_nxt = S_TRAIL;
                end
                S_TRAIL: begin
                    w_end_req   = r_match;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        if (w_tok_req && !w_room2) w_err_ovf_nxt = 1'b1;
    end

    assign w_end_data = {11'd0, w_end_abort, r_err_ovf, r_err_esc, r_err_sum,
                         ~(w_end_abort | r_err_ovf | r_err_esc | r_err_sum)};
    // The last slot is held back for the end token so a packet can always be closed.
    assign w_wr      = (w_tok_req && w_room2) || (w_end_req && ((r_count != L_FULL) || w_pop));
    assign w_wr_data = w_end_req ? w_end_data : w_tok_data;
    assign w_wr_type = w_end_req ? T_END : w_tok_type;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_match   <= 1'b0;
            r_started <= 1'b0;
            r_err_sum <= 1'b0;
            r_err_esc <= 1'b0;
            r_err_ovf <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_type[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_sum     <= w_sum_nxt;
            r_cnt     <= w_cnt_nxt;
            r_match   <= w_match_nxt;
            r_started <= w_started_nxt;
            r_err_sum <= w_err_sum_nxt;
            r_err_esc <= w_err_esc_nxt;
            r_err_ovf <= w_err_ovf_nxt;
            if (w_wr) begin
                r_mem_data[r_wptr] <= w_wr_data;
                r_mem_type[r_wptr] <= w_wr_type;
                r_wptr             <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
        end
    end

    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem_data[r_rptr];
    assign bus.out_type  = r_mem_type[r_rptr];
    assign busy          = (r_state != S_IDLE);

`ifdef SP_DECODER_STAT_EN
    logic [7:0] r_ok_cnt, r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ok_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (w_end_req) begin
            if (w_end_data[0]) r_ok_cnt  <= r_ok_cnt + 8'd1;
            else               r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign pkt_ok_cnt  = r_ok_cnt;
    assign pkt_err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_sp_packet_decoder.sv
// tb/tb_sp_packet_decoder.sv - packet-level reference model bench for sp_packet_decoder
module tb_sp_packet_decoder;
    localparam int          DEPTH = 4;
    localparam logic [15:0] ESC_S = 16'hFFA1;
    localparam logic [15:0] ESC_D = 16'hFFA3;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    sp_packet_decoder_if bus ();

`ifdef SP_DECODER_STAT_EN
    logic [7:0] ok_cnt, err_cnt;
`endif

    sp_packet_decoder #(.BLOCK_ADDR(8'hAB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
`ifdef SP_DECODER_STAT_EN
        .pkt_ok_cnt (ok_cnt),
        .pkt_err_cnt(err_cnt),
`endif
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;
    bit rand_ready = 0;
    bit ready_val = 1;

    logic [15:0] m_w[$];
    logic [17:0] m_q[$];
    logic [17:0] m_log[$];
    logic [17:0] exp_q[$];
    logic [15:0] tx_q[$];
    bit m_started, m_ovf;

    // Escape owed by the body after its first n words: -1 none, 0 data, 1 serv.
    function automatic int body_pend(int n);
        int pend;
        logic [15:0] w;
        pend = -1;
        for (int i = 0; i < n; i++) begin
            w = m_w[2+i];
            if (pend >= 0)       pend = -1;
            else if (w == ESC_S) pend = 1;
            else if (w == ESC_D) pend = 0;
        end
        return pend;
    endfunction

    function automatic logic [15:0] end_payload(bit ab);
        int n, sz;
        bit esc, se;
        logic [15:0] s;
        n = m_w.size();
        sz = int'(m_w[1][15:8]);
        esc = 0;
        se = 0;
        if (n >= sz + 2) esc = (body_pend(sz) >= 0);
        if (n >= sz + 3) begin
            s = '0;
            for (int i = 0; i < sz + 2; i++) s = s + m_w[i];
            se = (s != m_w[sz+2]);
        end
        return {11'd0, ab, m_ovf, esc, se, ~(ab | m_ovf | esc | se)};
    endfunction

    always @(posedge clk) begin : model
        int occ, k, sz, p;
        bit pop, have_tok, have_end, match;
        logic [17:0] tok, etok;
        occ = m_q.size();
        pop = (occ != 0) && bus.out_ready;
        have_tok = 0;
        have_end = 0;
        tok = '0;
        etok = '0;
        if (rst) begin
            m_q.delete();
            m_w.delete();
            m_started = 0;
            m_ovf = 0;
            pop = 0;
        end else if (bus.frame_abort) begin
            if (m_w.size() != 0 && m_started) begin
                have_end = 1;
                etok = {2'd3, end_payload(1'b1)};
            end
            m_w.delete();
            m_started = 0;
            m_ovf = 0;
        end else if (bus.in_valid) begin
            m_w.push_back(bus.in_data);
            k = m_w.size() - 1;
            if (k == 0) begin
                m_started = 0;
                m_ovf = 0;
            end else begin
                sz = int'(m_w[1][15:8]);
                match = (m_w[0][15:8] == 8'hAB);
                if (match && k == 1) begin
                    have_tok = 1;
                    tok = {2'd2, m_w[1]};
                end else if (match && k <= sz + 1) begin
                    p = body_pend(k - 2);
                    if (p >= 0) begin
                        have_tok = 1;
                        tok = {(p == 1) ? 2'd1 : 2'd0, bus.in_data};
                    end else if (bus.in_data != ESC_S && bus.in_data != ESC_D) begin
                        have_tok = 1;
                        tok = {2'd0, bus.in_data};
                    end
                end else if (match && k == sz + 3) begin
                    have_end = 1;
                    etok = {2'd3, end_payload(1'b0)};
                end
                if (k == sz + 3) m_w.delete();
            end
        end
        if (pop) m_log.push_back(m_q.pop_front());
        if (have_tok) begin
            if (occ <= DEPTH - 2) begin
                m_q.push_back(tok);
                if (tok[17:16] == 2'd2) m_started = 1;
            end else begin
                m_ovf = 1;
            end
        end
        if (have_end && (occ < DEPTH || pop)) m_q.push_back(etok);
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            total++;
            if (bus.out_valid !== (m_q.size() != 0)) begin
                bad++;
                $display("FAIL out_valid @%0t: got %b want %b", $time, bus.out_valid, m_q.size() != 0);
            end
            total++;
            if (busy !== (m_w.size() != 0)) begin
                bad++;
                $display("FAIL busy @%0t: got %b want %b", $time, busy, m_w.size() != 0);
            end
            if (m_q.size() != 0) begin
                total++;
                if ({bus.out_type, bus.out_data} !== m_q[0]) begin
                    bad++;
                    $display("FAIL token @%0t: got %h want %h", $time, {bus.out_type, bus.out_data}, m_q[0]);
                end
            end
        end
    end

    task automatic step(input logic [15:0] w, input bit v, input bit a);
        @(negedge clk);
        #1;
        bus.in_data = w;
        bus.in_valid = v;
        bus.frame_abort = a;
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    endtask

    task automatic send_tx();
        foreach (tx_q[i]) step(tx_q[i], 1'b1, 1'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        rand_ready = 0;
        ready_val = 1;
        step(16'h0, 1'b0, 1'b0);
        while (m_q.size() != 0 && guard < 200) begin
            step(16'h0, 1'b0, 1'b0);
            guard++;
        end
        step(16'h0, 1'b0, 1'b0);
        total++;
        if (guard >= 200) begin
            bad++;
            $display("FAIL drain timeout: got %0d tokens left want 0", m_q.size());
        end
    endtask

    task automatic check_log(input string name);
        drain();
        total++;
        if (m_log.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s count: got %0d want %0d", name, m_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (m_log[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s token %0d: got %h want %h", name, i, m_log[i], exp_q[i]);
                end
            end
        end
        m_log.delete();
        exp_q.delete();
    endtask

    task automatic pkt1(input logic [15:0] csum);
        tx_q = '{16'hAB00, 16'h06A2, ESC_S, 16'h0001, 16'h0002, 16'hAB45, ESC_D, ESC_S, csum, 16'h0000};
        send_tx();
    endtask

    task automatic exp_pkt1(input logic [15:0] end_pl);
        exp_q.push_back(18'h206A2);
        exp_q.push_back(18'h10001);
        exp_q.push_back(18'h00002);
        exp_q.push_back(18'h0AB45);
        exp_q.push_back(18'h0FFA1);
        exp_q.push_back({2'd3, end_pl});
    endtask

    task automatic rand_pkt();
        logic [7:0] addr;
        logic [15:0] s;
        int sz, r;
        addr = ($urandom_range(0, 3) != 0) ? 8'hAB : 8'($urandom_range(0, 255));
        sz = $urandom_range(0, 8);
        tx_q.delete();
        tx_q.push_back({addr, 8'h00});
        tx_q.push_back({8'(sz), 8'($urandom)});
        for (int i = 0; i < sz; i++) begin
            r = $urandom_range(0, 7);
            tx_q.push_back((r == 0) ? ESC_S : (r == 1) ? ESC_D : 16'($urandom));
        end
        s = '0;
        foreach (tx_q[i]) s = s + tx_q[i];
        if ($urandom_range(0, 3) == 0) s = s ^ 16'h0100;
        tx_q.push_back(s);
        tx_q.push_back(16'($urandom));
        foreach (tx_q[i]) begin
            repeat ($urandom_range(0, 2)) step(16'h0, 1'b0, 1'b0);
            if ($urandom_range(0, 39) == 0) begin
                step(tx_q[i], 1'($urandom_range(0, 1)), 1'b1);
                return;
            end
            step(tx_q[i], 1'b1, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.frame_abort = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total += 4;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_data !== 16'h0) begin bad++; $display("FAIL reset out_data: got %h want 0000", bus.out_data); end
        if (bus.out_type !== 2'd0) begin bad++; $display("FAIL reset out_type: got %h want 0", bus.out_type); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        chk_en = 1;

        pkt1(16'h5BCF);
        exp_pkt1(16'h0001);
        check_log("good_pkt");

        pkt1(16'h5BCE);
        exp_pkt1(16'h0002);
        check_log("bad_sum");

        tx_q = '{16'hAC00, 16'h0AB2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hB6B2, 16'h0000};
        send_tx();
        pkt1(16'h5BCF);
        exp_pkt1(16'h0001);
        check_log("foreign_then_good");

        tx_q = '{16'hAB00, 16'h01A2, ESC_S, 16'hAC43, 16'h0000};
        send_tx();
        exp_q.push_back(18'h201A2);
        exp_q.push_back(18'h30004);
        check_log("dangling_esc");

        ready_val = 0;
        pkt1(16'h5BCF);
        repeat (3) step(16'h0, 1'b0, 1'b0);
        total++;
        if (m_q.size() != 4) begin
            bad++;
            $display("FAIL ovf_held: got %0d want 4", m_q.size());
        end
        exp_q.push_back(18'h206A2);
        exp_q.push_back(18'h10001);
        exp_q.push_back(18'h00002);
        exp_q.push_back(18'h30008);
        check_log("overflow");

        tx_q = '{16'hAB00, 16'h06A2, ESC_S, 16'h0001};
        send_tx();
        step(16'h0, 1'b0, 1'b1);
        pkt1(16'h5BCF);
        exp_q.push_back(18'h206A2);
        exp_q.push_back(18'h10001);
        exp_q.push_back(18'h30010);
        exp_pkt1(16'h0001);
        check_log("abort");

        rand_ready = 1;
        for (int n = 0; n < 150; n++) begin
            rand_pkt();
            rand_ready = 1;
        end
        drain();
        m_log.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
